// File: rtl/operand_if.sv
// Operand-stage bus: command inputs, operand handshake toward the ALU and the
// register-file writeback port, bundled so master (driver) and slave (stage) share one definition.
interface operand_if #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
);
  logic              start;
  logic [AW-1:0]     rn;
  logic [AW-1:0]     rm;
  logic [1:0]        shift;
  logic              asel;
  logic              bsel;
  logic [DATA_W-1:0] imm;
  logic              busy;
  logic [DATA_W-1:0] val_A;
  logic [DATA_W-1:0] val_B;
  logic              out_valid;
  logic              out_ready;
  logic              wr_en;
  logic [AW-1:0]     wr_num;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output start, rn, rm, shift, asel, bsel, imm, out_ready, wr_en, wr_num, wr_data,
    input  busy, val_A, val_B, out_valid
  );

  modport slave (
    input  start, rn, rm, shift, asel, bsel, imm, out_ready, wr_en, wr_num, wr_data,
    output busy, val_A, val_B, out_valid
  );
endinterface

// File: rtl/operand_stage.sv
// Operand-fetch stage: 8-entry register file, two-cycle A/B read, 1-bit B shifter,
// asel/bsel muxes. Define OPERAND_BYPASS_EN for write-through forwarding on read edges.
module operand_stage #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = 3
) (
  input  logic       clk,
  input  logic       reset,
  operand_if.slave   bus,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ_A = 2'd1;
  localparam logic [1:0] READ_B = 2'd2;
  localparam logic [1:0] VALID  = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [AW-1:0]     rn_cap;
  logic [AW-1:0]     rm_cap;
  logic [1:0]        shift_cap;
  logic              asel_cap;
  logic              bsel_cap;
  logic [DATA_W-1:0] imm_cap;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] rd_b_shifted;

`ifdef OPERAND_BYPASS_EN
  // A write landing on the same edge as the read is forwarded into the operand.
  assign rd_a = (bus.wr_en && bus.wr_num == rn_cap) ? bus.wr_data : regs[rn_cap];
  assign rd_b = (bus.wr_en && bus.wr_num == rm_cap) ? bus.wr_data : regs[rm_cap];
`else
  assign rd_a = regs[rn_cap];
  assign rd_b = regs[rm_cap];
`endif

  always_comb begin
    rd_b_shifted = rd_b;
    case (shift_cap)
      2'b01:   rd_b_shifted = {rd_b[DATA_W-2:0], 1'b0};
      2'b10:   rd_b_shifted = {1'b0, rd_b[DATA_W-1:1]};
      2'b11:   rd_b_shifted = {rd_b[DATA_W-1], rd_b[DATA_W-1:1]};
      default: rd_b_shifted = rd_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      rn_cap    <= '0;
      rm_cap    <= '0;
      shift_cap <= '0;
      asel_cap  <= 1'b0;
      bsel_cap  <= 1'b0;
      imm_cap   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (bus.wr_en) regs[bus.wr_num] <= bus.wr_data;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rn_cap    <= bus.rn;
            rm_cap    <= bus.rm;
            shift_cap <= bus.shift;
            asel_cap  <= bus.asel;
            bsel_cap  <= bus.bsel;
            imm_cap   <= bus.imm;
            state     <= READ_A;
          end
        end
        READ_A: begin
          a_reg <= rd_a;
          state <= READ_B;
        end
        READ_B: begin
          b_reg <= rd_b_shifted;
          state <= VALID;
        end
        VALID: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake: out_valid rises once both operands are captured and stays high with
  // val_A/val_B frozen until a cycle with out_ready=1; out_ready is a don't-care otherwise.
  assign bus.out_valid = (state == VALID);
  assign bus.busy      = (state != IDLE);
  assign bus.val_A     = asel_cap ? '0 : a_reg;
  assign bus.val_B     = bsel_cap ? imm_cap : b_reg;
  assign dbg_state     = state;

endmodule
